// File: rtl/dahb_bridge_if.sv
// Signal bundle between the data memory controller / AHB-Lite fabric and dahb_bridge.
// The master modport is the bridge's view; slave is the requester-plus-bus view.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

interface dahb_bridge_if;
  logic                   DAHB_access;
  logic                   DAHB_rd0_wr1;
  logic [2:0]             DAHB_size;
  logic [`ADDR_WIDTH-1:0] DAHB_addr;
  logic [`DATA_WIDTH-1:0] DAHB_write_data;
  logic                   DAHB_trans_buffer_full;
  logic [`DATA_WIDTH-1:0] DAHB_read_data;
  logic                   DAHB_read_data_valid;
  logic                   DAHB_error;
  logic                   DAHB_busy;
  logic [`ADDR_WIDTH-1:0] HADDR;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [2:0]             HSIZE;
  logic [2:0]             HBURST;
  logic [3:0]             HPROT;
  logic [`DATA_WIDTH-1:0] HWDATA;
  logic [`DATA_WIDTH-1:0] HRDATA;
  logic                   HREADY;
  logic                   HRESP;

  modport master (
    input  DAHB_access, DAHB_rd0_wr1, DAHB_size, DAHB_addr, DAHB_write_data,
    input  HRDATA, HREADY, HRESP,
    output DAHB_trans_buffer_full, DAHB_read_data, DAHB_read_data_valid, DAHB_error, DAHB_busy,
    output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );

  modport slave (
    output DAHB_access, DAHB_rd0_wr1, DAHB_size, DAHB_addr, DAHB_write_data,
    output HRDATA, HREADY, HRESP,
    input  DAHB_trans_buffer_full, DAHB_read_data, DAHB_read_data_valid, DAHB_error, DAHB_busy,
    input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
  );
endinterface

// File: rtl/dahb_bridge.sv
// Data-side AHB-Lite master bridge: in-order request FIFO feeding pipelined SINGLE
// transfers, returning raw lane-aligned read data and error pulses to the MEM stage.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module dahb_bridge #(
  parameter int         BUF_DEPTH = 2,
  parameter logic [3:0] HPROT_VAL = 4'b0001
) (
  input logic           cpu_clk,
  input logic           cpu_rstn,
  dahb_bridge_if.master dahb
);
  localparam int         AW          = `ADDR_WIDTH;
  localparam int         DW          = `DATA_WIDTH;
  localparam int         PTR_W       = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int         CNT_W       = PTR_W + 1;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NSEQ = 2'b10;

  typedef struct packed {
    logic          wr;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t             r_fifo [BUF_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;

  logic             r_dp_vld_p1;
  logic             r_dp_wr_p1;
  logic [DW-1:0]    r_hwdata_p1;
  logic             r_rvld_p2;
  logic             r_err_p2;
  logic [DW-1:0]    r_rdata_p2;

  req_t             w_head;
  logic             w_full;
  logic             w_nonempty;
  logic             w_accept;
  logic             w_issue;
  logic             w_addr_acc;
  logic             w_dp_done;

  assign w_head     = r_fifo[r_rptr];
  assign w_full     = (r_count == CNT_W'(BUF_DEPTH));
  assign w_nonempty = (r_count != '0);
  assign w_accept   = dahb.DAHB_access && !w_full;
  // Holding off issue during any ERROR cycle keeps the next head queued until the
  // failing transfer has fully retired.
  assign w_issue    = w_nonempty && !(r_dp_vld_p1 && dahb.HRESP);
  assign w_addr_acc = w_issue && dahb.HREADY;
  assign w_dp_done  = r_dp_vld_p1 && dahb.HREADY;

  // Request storage: data only, no reset needed.
  always_ff @(posedge cpu_clk) begin
    if (w_accept) begin
      r_fifo[r_wptr] <= '{wr:    dahb.DAHB_rd0_wr1,
                          size:  dahb.DAHB_size,
                          addr:  dahb.DAHB_addr,
                          wdata: dahb.DAHB_write_data};
    end
  end

  // Stage p0 -> p1: FIFO pointers/count and address-to-data phase handoff.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_dp_vld_p1 <= 1'b0;
      r_dp_wr_p1  <= 1'b0;
      r_hwdata_p1 <= '0;
    end else begin
      if (w_accept)   r_wptr <= r_wptr + PTR_W'(1);
      if (w_addr_acc) r_rptr <= r_rptr + PTR_W'(1);
      if (w_accept && !w_addr_acc)      r_count <= r_count + CNT_W'(1);
      else if (!w_accept && w_addr_acc) r_count <= r_count - CNT_W'(1);

      if (w_addr_acc) begin
        r_dp_vld_p1 <= 1'b1;
        r_dp_wr_p1  <= w_head.wr;
      end else if (w_dp_done) begin
        r_dp_vld_p1 <= 1'b0;
      end
      if (w_addr_acc && w_head.wr) r_hwdata_p1 <= w_head.wdata;
    end
  end

  // Stage p1 -> p2: completion response back to the MEM stage.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      r_rvld_p2  <= 1'b0;
      r_err_p2   <= 1'b0;
      r_rdata_p2 <= '0;
    end else begin
      r_rvld_p2 <= w_dp_done && !r_dp_wr_p1;
      r_err_p2  <= w_dp_done && dahb.HRESP;
      if (w_dp_done && !r_dp_wr_p1) r_rdata_p2 <= dahb.HRESP ? '0 : dahb.HRDATA;
    end
  end

  always_comb begin
    dahb.HTRANS = HTRANS_IDLE;
    dahb.HADDR  = '0;
    dahb.HWRITE = 1'b0;
    dahb.HSIZE  = 3'b000;
    if (w_issue) begin
      dahb.HTRANS = HTRANS_NSEQ;
      dahb.HADDR  = w_head.addr;
      dahb.HWRITE = w_head.wr;
      dahb.HSIZE  = w_head.size;
    end
  end

  assign dahb.HBURST                 = 3'b000;
  assign dahb.HPROT                  = HPROT_VAL;
  assign dahb.HWDATA                 = r_hwdata_p1;
  assign dahb.DAHB_trans_buffer_full = w_full;
  assign dahb.DAHB_read_data         = r_rdata_p2;
  assign dahb.DAHB_read_data_valid   = r_rvld_p2;
  assign dahb.DAHB_error             = r_err_p2;
  assign dahb.DAHB_busy              = w_nonempty || r_dp_vld_p1;

endmodule

// File: tb/tb_dahb_bridge.sv
// Self-checking bench for dahb_bridge: directed scenarios plus a randomized run
// against a transaction-level memory model acting as the AHB slave.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dahb_bridge;
  localparam int          BUF_DEPTH = 2;
  localparam logic [31:0] RBASE     = 32'h0000_0100;

  typedef struct { logic wr; int idx; logic [31:0] wdata; } req_s;
  typedef struct { logic rvld; logic err; logic [31:0] data; } evt_s;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dahb_bridge_if bus();

  dahb_bridge #(.BUF_DEPTH(BUF_DEPTH), .HPROT_VAL(4'b0001)) dut (
    .cpu_clk  (clk),
    .cpu_rstn (rstn),
    .dahb     (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.DAHB_access     = 1'b0;
    bus.DAHB_rd0_wr1    = 1'b0;
    bus.DAHB_size       = 3'b000;
    bus.DAHB_addr       = '0;
    bus.DAHB_write_data = '0;
    bus.HRDATA          = '0;
    bus.HREADY          = 1'b1;
    bus.HRESP           = 1'b0;
  endtask

  task automatic req(input logic wr, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d);
    bus.DAHB_access     = 1'b1;
    bus.DAHB_rd0_wr1    = wr;
    bus.DAHB_size       = sz;
    bus.DAHB_addr       = a;
    bus.DAHB_write_data = d;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({bus.DAHB_trans_buffer_full, bus.DAHB_read_data_valid, bus.DAHB_error, bus.DAHB_busy} !== 4'b0) begin errors++; $display("FAIL rst_flags act=%b exp=0000", {bus.DAHB_trans_buffer_full, bus.DAHB_read_data_valid, bus.DAHB_error, bus.DAHB_busy}); end
    checks++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0) begin errors++; $display("FAIL rst_htrans_haddr act=%h/%h exp=0/0", bus.HTRANS, bus.HADDR); end
    checks++; if (bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'b000) begin errors++; $display("FAIL rst_hwrite_hsize act=%b/%h exp=0/0", bus.HWRITE, bus.HSIZE); end
    checks++; if (bus.HWDATA !== 32'h0 || bus.DAHB_read_data !== 32'h0) begin errors++; $display("FAIL rst_data act=%h/%h exp=0/0", bus.HWDATA, bus.DAHB_read_data); end
    checks++; if (bus.HBURST !== 3'b000 || bus.HPROT !== 4'b0001) begin errors++; $display("FAIL rst_burst_prot act=%h/%h exp=0/1", bus.HBURST, bus.HPROT); end
    #2 rstn = 1'b1;
    tick();
  endtask

  task automatic test_byte_write();
    tick(); req(1'b1, 3'b000, 32'h4000_0001, 32'h0000_AB00);
    tick(); bus.DAHB_access = 1'b0; #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HWRITE !== 1'b1 || bus.HSIZE !== 3'b000) begin errors++; $display("FAIL bw_ctrl act=%h/%b/%h exp=2/1/0", bus.HTRANS, bus.HWRITE, bus.HSIZE); end
    checks++; if (bus.HADDR !== 32'h4000_0001) begin errors++; $display("FAIL bw_haddr act=%h exp=40000001", bus.HADDR); end
    tick();
    checks++; if (bus.HWDATA !== 32'h0000_AB00) begin errors++; $display("FAIL bw_hwdata act=%h exp=0000ab00", bus.HWDATA); end
    checks++; if (bus.HTRANS !== 2'b00 || bus.DAHB_busy !== 1'b1) begin errors++; $display("FAIL bw_dphase act=%h/%b exp=0/1", bus.HTRANS, bus.DAHB_busy); end
    tick();
    checks++; if (bus.DAHB_read_data_valid !== 1'b0 || bus.DAHB_busy !== 1'b0) begin errors++; $display("FAIL bw_done act=%b/%b exp=0/0", bus.DAHB_read_data_valid, bus.DAHB_busy); end
  endtask

  task automatic test_read_wait();
    int pulses = 0;
    int at_k   = -1;
    logic [31:0] got = '0;
    tick(); req(1'b0, 3'b010, 32'h4000_0010, 32'h0);
    tick(); bus.DAHB_access = 1'b0; #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h4000_0010 || bus.HWRITE !== 1'b0 || bus.HSIZE !== 3'b010) begin errors++; $display("FAIL rw_aphase act=%h/%h/%b/%h exp=2/40000010/0/2", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HSIZE); end
    for (int k = 2; k <= 6; k++) begin
      tick();
      bus.HREADY = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      bus.HRDATA = (k == 4) ? 32'h1234_5678 : $urandom;
      #1;
      if (bus.DAHB_read_data_valid) begin pulses++; at_k = k; got = bus.DAHB_read_data; end
    end
    checks++; if (pulses != 1 || at_k != 5) begin errors++; $display("FAIL rw_pulse act=%0d@%0d exp=1@5", pulses, at_k); end
    checks++; if (got !== 32'h1234_5678) begin errors++; $display("FAIL rw_data act=%h exp=12345678", got); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [31:0] w0, w1, rd;
    w0 = $urandom; w1 = $urandom; rd = $urandom;
    tick(); req(1'b1, 3'b010, 32'h10, w0); #1;
    checks++; if (bus.DAHB_trans_buffer_full !== 1'b0) begin errors++; $display("FAIL b2b_full0 act=%b exp=0", bus.DAHB_trans_buffer_full); end
    tick(); req(1'b1, 3'b010, 32'h14, w1); #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h10 || bus.HWRITE !== 1'b1 || bus.DAHB_trans_buffer_full !== 1'b0) begin errors++; $display("FAIL b2b_a0 act=%h/%h/%b/%b exp=2/10/1/0", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.DAHB_trans_buffer_full); end
    tick(); req(1'b0, 3'b010, 32'h18, 32'h0); #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h14 || bus.HWDATA !== w0 || bus.DAHB_trans_buffer_full !== 1'b0) begin errors++; $display("FAIL b2b_a1 act=%h/%h/%h exp=2/14/%h", bus.HTRANS, bus.HADDR, bus.HWDATA, w0); end
    tick(); bus.DAHB_access = 1'b0; bus.HRDATA = $urandom; #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h18 || bus.HWRITE !== 1'b0 || bus.HWDATA !== w1) begin errors++; $display("FAIL b2b_a2 act=%h/%h/%b/%h exp=2/18/0/%h", bus.HTRANS, bus.HADDR, bus.HWRITE, bus.HWDATA, w1); end
    tick(); bus.HRDATA = rd; #1;
    checks++; if (bus.HTRANS !== 2'b00 || bus.DAHB_read_data_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle act=%h/%b exp=0/0", bus.HTRANS, bus.DAHB_read_data_valid); end
    tick(); bus.HRDATA = $urandom;
    checks++; if (bus.DAHB_read_data_valid !== 1'b1 || bus.DAHB_read_data !== rd) begin errors++; $display("FAIL b2b_rdata act=%b/%h exp=1/%h", bus.DAHB_read_data_valid, bus.DAHB_read_data, rd); end
    idle_inputs();
  endtask

  task automatic test_full();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    tick(); req(1'b1, 3'b010, 32'h40, a);
    tick(); bus.DAHB_access = 1'b0;
    tick(); bus.HREADY = 1'b0; req(1'b1, 3'b010, 32'h44, b);
    tick(); req(1'b1, 3'b010, 32'h48, c); #1;
    checks++; if (bus.DAHB_trans_buffer_full !== 1'b0 || bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h44) begin errors++; $display("FAIL full_one act=%b/%h/%h exp=0/2/44", bus.DAHB_trans_buffer_full, bus.HTRANS, bus.HADDR); end
    tick(); req(1'b1, 3'b010, 32'h4C, $urandom); #1;
    checks++; if (bus.DAHB_trans_buffer_full !== 1'b1) begin errors++; $display("FAIL full_set act=%b exp=1", bus.DAHB_trans_buffer_full); end
    tick(); bus.DAHB_access = 1'b0; bus.HREADY = 1'b1; #1;
    checks++; if (bus.DAHB_trans_buffer_full !== 1'b1 || bus.HADDR !== 32'h44 || bus.HWDATA !== a) begin errors++; $display("FAIL full_hold act=%b/%h/%h exp=1/44/%h", bus.DAHB_trans_buffer_full, bus.HADDR, bus.HWDATA, a); end
    tick();
    checks++; if (bus.DAHB_trans_buffer_full !== 1'b0 || bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h48 || bus.HWDATA !== b) begin errors++; $display("FAIL full_drain act=%b/%h/%h/%h exp=0/2/48/%h", bus.DAHB_trans_buffer_full, bus.HTRANS, bus.HADDR, bus.HWDATA, b); end
    tick();
    checks++; if (bus.HTRANS !== 2'b00 || bus.HWDATA !== c || bus.DAHB_busy !== 1'b1) begin errors++; $display("FAIL full_dropped act=%h/%h/%b exp=0/%h/1", bus.HTRANS, bus.HWDATA, bus.DAHB_busy, c); end
    tick();
    checks++; if (bus.DAHB_busy !== 1'b0) begin errors++; $display("FAIL full_idle act=%b exp=0", bus.DAHB_busy); end
  endtask

  task automatic test_error();
    logic [31:0] we;
    we = $urandom;
    tick(); req(1'b0, 3'b010, 32'h20, 32'h0);
    tick(); req(1'b1, 3'b010, 32'h24, we); #1;
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h20) begin errors++; $display("FAIL err_aphase act=%h/%h exp=2/20", bus.HTRANS, bus.HADDR); end
    tick(); bus.DAHB_access = 1'b0; bus.HRESP = 1'b1; bus.HREADY = 1'b0; bus.HRDATA = 32'hDEAD_BEEF; #1;
    checks++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.DAHB_busy !== 1'b1) begin errors++; $display("FAIL err_first act=%h/%h/%b exp=0/0/1", bus.HTRANS, bus.HADDR, bus.DAHB_busy); end
    tick(); bus.HREADY = 1'b1; #1;
    checks++; if (bus.HTRANS !== 2'b00 || bus.DAHB_read_data_valid !== 1'b0 || bus.DAHB_error !== 1'b0) begin errors++; $display("FAIL err_second act=%h/%b/%b exp=0/0/0", bus.HTRANS, bus.DAHB_read_data_valid, bus.DAHB_error); end
    tick(); bus.HRESP = 1'b0; #1;
    checks++; if (bus.DAHB_read_data_valid !== 1'b1 || bus.DAHB_error !== 1'b1 || bus.DAHB_read_data !== 32'h0) begin errors++; $display("FAIL err_resp act=%b/%b/%h exp=1/1/0", bus.DAHB_read_data_valid, bus.DAHB_error, bus.DAHB_read_data); end
    checks++; if (bus.HTRANS !== 2'b10 || bus.HADDR !== 32'h24 || bus.HWRITE !== 1'b1) begin errors++; $display("FAIL err_resume act=%h/%h/%b exp=2/24/1", bus.HTRANS, bus.HADDR, bus.HWRITE); end
    tick();
    checks++; if (bus.DAHB_read_data_valid !== 1'b0 || bus.DAHB_error !== 1'b0 || bus.HWDATA !== we) begin errors++; $display("FAIL err_after act=%b/%b/%h exp=0/0/%h", bus.DAHB_read_data_valid, bus.DAHB_error, bus.HWDATA, we); end
    tick();
    checks++; if (bus.DAHB_busy !== 1'b0) begin errors++; $display("FAIL err_idle act=%b exp=0", bus.DAHB_busy); end
    idle_inputs();
  endtask

  task automatic test_random(input int n_stim);
    req_s        pend_q[$];
    evt_s        evt_q[$];
    req_s        r;
    evt_s        e;
    logic [31:0] ref_mem [16];
    logic [31:0] slv_mem [16];
    logic        s_dp, s_wr, s_err, stim, dp_done, rerr;
    int          s_idx, s_wait, s_errc, diffs;
    logic [31:0] s_wdata;
    s_dp = 1'b0; s_wr = 1'b0; s_err = 1'b0; s_idx = 0; s_wait = 0; s_errc = 0; s_wdata = '0;
    for (int i = 0; i < 16; i++) begin ref_mem[i] = $urandom; slv_mem[i] = ref_mem[i]; end
    idle_inputs();
    for (int c = 0; c < n_stim + 300; c++) begin
      stim = (c < n_stim);
      tick();
      if (bus.DAHB_read_data_valid || bus.DAHB_error) begin
        checks++;
        if (evt_q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious act=%b/%b exp=none", bus.DAHB_read_data_valid, bus.DAHB_error);
        end else begin
          e = evt_q.pop_front();
          if (bus.DAHB_read_data_valid !== e.rvld || bus.DAHB_error !== e.err || (e.rvld && bus.DAHB_read_data !== e.data)) begin
            errors++; $display("FAIL rnd_resp act=%b/%b/%h exp=%b/%b/%h", bus.DAHB_read_data_valid, bus.DAHB_error, bus.DAHB_read_data, e.rvld, e.err, e.data);
          end
        end
      end
      checks++; if (bus.DAHB_trans_buffer_full !== (pend_q.size() == BUF_DEPTH)) begin errors++; $display("FAIL rnd_full act=%b exp=%b", bus.DAHB_trans_buffer_full, pend_q.size() == BUF_DEPTH); end
      checks++; if (bus.DAHB_busy !== (pend_q.size() != 0 || s_dp)) begin errors++; $display("FAIL rnd_busy act=%b exp=%b", bus.DAHB_busy, (pend_q.size() != 0 || s_dp)); end
      // AHB slave response for this cycle
      bus.HRESP = 1'b0; bus.HREADY = 1'b1; bus.HRDATA = $urandom;
      if (s_dp) begin
        if (s_err) begin
          bus.HRESP = 1'b1; bus.HREADY = (s_errc >= 1); s_errc++;
        end else if (s_wait > 0) begin
          bus.HREADY = 1'b0; s_wait--;
        end else if (!s_wr) begin
          bus.HRDATA = slv_mem[s_idx];
        end
      end
      // Requester, with in-order reference semantics applied at acceptance
      bus.DAHB_access = 1'b0;
      if (stim && $urandom_range(0, 2) != 0) begin
        r.wr = 1'($urandom_range(0, 1)); r.idx = $urandom_range(0, 15); r.wdata = $urandom;
        req(r.wr, 3'b010, RBASE + 32'(4 * r.idx), r.wdata);
        if (pend_q.size() < BUF_DEPTH) begin
          pend_q.push_back(r);
          rerr = (r.idx >= 14);
          if (!r.wr) begin
            e.rvld = 1'b1; e.err = rerr; e.data = rerr ? 32'h0 : ref_mem[r.idx]; evt_q.push_back(e);
          end else if (rerr) begin
            e.rvld = 1'b0; e.err = 1'b1; e.data = 32'h0; evt_q.push_back(e);
          end else begin
            ref_mem[r.idx] = r.wdata;
          end
        end
      end
      #1;
      if (bus.HRESP) begin
        checks++; if (bus.HTRANS !== 2'b00) begin errors++; $display("FAIL rnd_err_idle act=%h exp=0", bus.HTRANS); end
      end
      if (s_dp && bus.HREADY && s_wr && !s_err) begin
        checks++; if (bus.HWDATA !== s_wdata) begin errors++; $display("FAIL rnd_hwdata act=%h exp=%h", bus.HWDATA, s_wdata); end
        slv_mem[s_idx] = bus.HWDATA;
      end
      dp_done = s_dp && bus.HREADY;
      if (bus.HTRANS == 2'b10 && bus.HREADY) begin
        checks++;
        if (pend_q.size() == 0) begin
          errors++; $display("FAIL rnd_issue_empty act=%h exp=idle", bus.HADDR);
        end else begin
          r = pend_q.pop_front();
          if (bus.HADDR !== RBASE + 32'(4 * r.idx) || bus.HWRITE !== r.wr || bus.HSIZE !== 3'b010) begin
            errors++; $display("FAIL rnd_issue act=%h/%b/%h exp=%h/%b/2", bus.HADDR, bus.HWRITE, bus.HSIZE, RBASE + 32'(4 * r.idx), r.wr);
          end
          s_dp = 1'b1; s_wr = r.wr; s_idx = r.idx; s_wdata = r.wdata;
          s_err = (r.idx >= 14); s_errc = 0; s_wait = s_err ? 0 : $urandom_range(0, 2);
        end
      end else if (dp_done) begin
        s_dp = 1'b0;
      end
      if (!stim && pend_q.size() == 0 && !s_dp && evt_q.size() == 0) break;
    end
    checks++; if (pend_q.size() != 0 || evt_q.size() != 0 || s_dp) begin errors++; $display("FAIL rnd_drain act=%0d/%0d/%b exp=0/0/0", pend_q.size(), evt_q.size(), s_dp); end
    diffs = 0;
    for (int i = 0; i < 16; i++) if (slv_mem[i] !== ref_mem[i]) diffs++;
    checks++; if (diffs != 0) begin errors++; $display("FAIL rnd_mem act=%0d_diffs exp=0", diffs); end
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_mid();
    tick(); req(1'b0, 3'b010, 32'h30, 32'h0);
    tick(); req(1'b1, 3'b010, 32'h34, 32'hA5A5_0001);
    tick(); req(1'b1, 3'b010, 32'h38, 32'hA5A5_0002); bus.HREADY = 1'b0;
    tick(); bus.DAHB_access = 1'b0; #1;
    checks++; if (bus.DAHB_busy !== 1'b1 || bus.DAHB_trans_buffer_full !== 1'b1) begin errors++; $display("FAIL rm_pre act=%b/%b exp=1/1", bus.DAHB_busy, bus.DAHB_trans_buffer_full); end
    #2 rstn = 1'b0;
    #1;
    checks++; if ({bus.DAHB_trans_buffer_full, bus.DAHB_read_data_valid, bus.DAHB_error, bus.DAHB_busy, bus.HWRITE} !== 5'b0) begin errors++; $display("FAIL rm_flags act=%b exp=00000", {bus.DAHB_trans_buffer_full, bus.DAHB_read_data_valid, bus.DAHB_error, bus.DAHB_busy, bus.HWRITE}); end
    checks++; if (bus.HTRANS !== 2'b00 || bus.HADDR !== 32'h0 || bus.HSIZE !== 3'b000 || bus.HWDATA !== 32'h0 || bus.DAHB_read_data !== 32'h0) begin errors++; $display("FAIL rm_bus act=%h/%h/%h/%h/%h exp=0", bus.HTRANS, bus.HADDR, bus.HSIZE, bus.HWDATA, bus.DAHB_read_data); end
    @(posedge clk);
    #3 rstn = 1'b1;
    bus.HREADY = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(); bus.HRDATA = $urandom;
      checks++; if (bus.DAHB_read_data_valid !== 1'b0 || bus.DAHB_error !== 1'b0 || bus.HTRANS !== 2'b00 || bus.DAHB_busy !== 1'b0) begin errors++; $display("FAIL rm_post act=%b/%b/%h/%b exp=0/0/0/0", bus.DAHB_read_data_valid, bus.DAHB_error, bus.HTRANS, bus.DAHB_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_byte_write();
    test_read_wait();
    test_back_to_back();
    test_full();
    test_error();
    test_random(600);
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/dahb_bridge.md
# dahb_bridge

Data-side AHB-Lite master bridge: the responder end of the core's DAHB request interface from the data memory controller. Buffers single data accesses in a small in-order request FIFO and issues them as pipelined AHB-Lite SINGLE transfers. Returns raw, lane-aligned read data to the MEM stage; lane extraction and sign extension stay in the data memory controller. Sits between the core's MEM stage and the system data bus.

## Interface
- BUF_DEPTH, 2, request FIFO entries; must be 2, 4 or 8
- HPROT_VAL, 4'b0001, constant HPROT value (data access)
- cpu_clk  in  1  cpu clock; also the AHB clock
- cpu_rstn  in  1  async active-low reset
- DAHB_access  in  1  request strobe; one request per cycle when accepted
- DAHB_rd0_wr1  in  1  0 read, 1 write
- DAHB_size  in  3  3'b000 byte, 3'b001 half, 3'b010 word
- DAHB_addr  in  `ADDR_WIDTH  byte address
- DAHB_write_data  in  `DATA_WIDTH  lane-aligned write data
- DAHB_trans_buffer_full  out  1  FIFO full; requests are not accepted
- DAHB_read_data  out  `DATA_WIDTH  registered read data
- DAHB_read_data_valid  out  1  one-cycle pulse per completed read
- DAHB_error  out  1  one-cycle pulse per transfer completed with ERROR
- DAHB_busy  out  1  FIFO non-empty or data phase outstanding
- HADDR  out  `ADDR_WIDTH; HTRANS  out  2; HWRITE  out  1; HSIZE  out  3; HBURST  out  3 (fixed 3'b000); HPROT  out  4 (HPROT_VAL)
- HWDATA  out  `DATA_WIDTH  data-phase write data
- HRDATA  in  `DATA_WIDTH; HREADY  in  1; HRESP  in  1 (0 OKAY, 1 ERROR)

## Operation
- Accept is defined as `accept = DAHB_access && !DAHB_trans_buffer_full`. On accept, push {rd0_wr1, size, addr, wdata}. A DAHB_access while full is ignored and is not queued. Each accepting cycle pushes one entry; the requester must deassert DAHB_access or drop it after acceptance.
- DAHB_trans_buffer_full = (count == BUF_DEPTH). It is decoded combinationally from the registered count.
- Issue is defined as `issue = fifo_nonempty && !(dp_valid && HRESP)`.
  - When issue is high: HTRANS = 2'b10 (NONSEQ), and HADDR/HWRITE/HSIZE come from the FIFO head.
  - Otherwise: HTRANS = 2'b00 (IDLE), and HADDR/HWRITE/HSIZE = 0.
- Address phase accepted is defined as `issue && HREADY`. On acceptance:
  - Pop the FIFO head.
  - Load the data-phase registers dp_valid=1, dp_write, dp_wdata.
- Data-phase completion is defined as `dp_valid && HREADY`. On completion:
  - Clear dp_valid, unless a new address phase is accepted in the same cycle; in that case dp is reloaded.
  - Read: register HRDATA into DAHB_read_data and pulse DAHB_read_data_valid next cycle.
  - HRESP=1: pulse DAHB_error next cycle. For a read, also return DAHB_read_data=0 with valid pulsed.
- HWDATA = dp_wdata while dp_valid && dp_write; otherwise hold its last value.
- Transfers complete strictly in order; there is no reordering and no read bypass of queued writes.
- Error response (two-cycle AHB-Lite):
  - First cycle (HRESP=1, HREADY=0): HTRANS is forced IDLE, so the pending head is not issued and stays queued.
  - Second cycle (HRESP=1, HREADY=1): the transfer completes with error, and issue resumes the following cycle.
- Simultaneous push and pop: count is unchanged. Push on empty plus issue in the same cycle cannot occur, because the head becomes visible only the cycle after the push.
- Pointers wrap modulo BUF_DEPTH. count is in the range 0..BUF_DEPTH.
- DAHB_busy = (count != 0) || dp_valid.

## Timing
- Reset values: DAHB_trans_buffer_full=0, DAHB_read_data=0, DAHB_read_data_valid=0, DAHB_error=0, DAHB_busy=0, HTRANS=IDLE, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, FIFO empty, dp_valid=0.
- Zero-wait latency, with accept in cycle N:
  - N+1: address phase.
  - N+2: data phase, HWDATA valid.
  - N+3: DAHB_read_data_valid.
- Each HREADY-low cycle in the data phase adds one cycle of latency.
- Back-to-back issue: one address phase per cycle when HREADY=1. The address phase of transfer k+1 overlaps the data phase of transfer k.
- Reset asserted mid-transfer: all state clears asynchronously, queued requests are discarded, and no valid or error pulse is generated.

## Test plan
- Byte write: accept at N with addr 0x4000_0001, size 0, wdata 0x0000_AB00.
  - N+1: HTRANS=NONSEQ, HWRITE=1, HSIZE=0, HADDR=0x4000_0001.
  - N+2: HWDATA=0x0000_AB00.
  - No DAHB_read_data_valid.
- Word read of 0x4000_0010 at N, HREADY low for 2 data-phase cycles, HRDATA=0x1234_5678 → single DAHB_read_data_valid pulse at N+5 with DAHB_read_data=0x1234_5678.
- Write 0x10, write 0x14, read 0x18 accepted in consecutive cycles N..N+2, zero wait:
  - NONSEQ at N+1, N+2, N+3.
  - Read valid at N+5.
  - count never exceeds 2.
- BUF_DEPTH=2, HREADY held low, one transfer stuck in data phase:
  - Push two requests → full=1.
  - A third DAHB_access is ignored.
  - Release HREADY → both queued requests issue and full drops.
- Read gets a two-cycle ERROR, with a write queued behind it:
  - HTRANS=IDLE in the first error cycle.
  - Next cycle: DAHB_read_data_valid=1 with data 0, and DAHB_error=1.
  - The queued write then issues NONSEQ.
- Assert cpu_rstn low during a read data phase with 2 entries queued → all outputs return to reset values immediately, and no pulses occur after release.
